// File: rtl/cp_pkg.sv
// cp_pkg: shared widths, the fetch-queue entry type and small helpers for the fetch stage.
`default_nettype none

package cp_pkg;

   localparam int XLEN = 32;
   localparam int ILEN = 32;

   localparam logic [ILEN-1:0] CP_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [ILEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

`default_nettype wire

// File: rtl/cp_fetch_fifo.sv
// cp_fetch_fifo: synchronous FIFO with occupancy count, flush and combinational head read.
`default_nettype none

module cp_fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] cnt;
   logic             empty;
   logic             full;
   logic             do_push;
   logic             do_pop;

   // Explicit wrap so depths that are not a power of two still work.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty   = (cnt == '0);
   assign full    = (cnt == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];
   assign count   = cnt;

   always_ff @(posedge clk_i) begin
      if (do_push && !flush) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         if (do_push && !do_pop) begin
            cnt <= cnt + CNT_W'(1);
         end else if (!do_push && do_pop) begin
            cnt <= cnt - CNT_W'(1);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/cp_instr_fetch.sv
// cp_instr_fetch: PC owner, credit-based imem issue, in-order instruction queue and redirect flush.
// Optional macro CP_FETCH_PERF_EN adds fetch_cnt_o / stall_cnt_o performance counters.
`default_nettype none

module cp_instr_fetch
   import cp_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2,
   parameter int          MAX_OUTST  = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic [31:0] instr_data_o,
   output logic [31:0] pc_o
`ifdef CP_FETCH_PERF_EN
   ,
   output logic [31:0] fetch_cnt_o,
   output logic [31:0] stall_cnt_o
`endif
);

   localparam int QCNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int TCNT_W = $clog2(MAX_OUTST + 1);
   // Issue credit ignores words still to be discarded, so repeated redirects can
   // stack more than MAX_OUTST discards; give that counter generous headroom.
   localparam int DISC_W = TCNT_W + 4;

   logic [XLEN-1:0]   pc_q;
   logic [DISC_W-1:0] discard;
   logic [TCNT_W-1:0] outstanding;
   logic [QCNT_W-1:0] q_count;
   fetch_entry_t      q_wdata;
   fetch_entry_t      q_rdata;
   logic [XLEN-1:0]   tag_pc;
   logic              issue_ok;
   logic              issue;
   logic              rsp_take;
   logic              rsp_drop;
   logic              rsp_inflight;
   logic              handoff;
   logic              unused_pc_bits;

   assign unused_pc_bits = ^redirect_pc_i[1:0];

   assign issue_ok = rst_ni && !redirect_i
                     && ((int'(q_count) + int'(outstanding)) < FIFO_DEPTH)
                     && (int'(outstanding) < MAX_OUTST);
   assign issue    = issue_ok && imem_gnt_i;

   assign rsp_drop     = imem_rvalid_i && (discard != '0);
   assign rsp_take     = imem_rvalid_i && (discard == '0) && (outstanding != '0);
   assign rsp_inflight = imem_rvalid_i && ((discard != '0) || (outstanding != '0));

   assign imem_req_o  = issue_ok;
   assign imem_addr_o = pc_q;

   assign instr_valid_o = (q_count != '0);
   assign instr_data_o  = instr_valid_o ? q_rdata.instr : '0;
   assign pc_o          = instr_valid_o ? q_rdata.pc    : '0;
   assign handoff       = instr_valid_o && instr_ready_i;

   assign q_wdata.instr = imem_rdata_i;
   assign q_wdata.pc    = tag_pc;

   cp_fetch_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_instr_q (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .flush  (redirect_i),
      .push   (rsp_take),
      .wdata  (q_wdata),
      .pop    (handoff),
      .rdata  (q_rdata),
      .count  (q_count)
   );

   // The tag queue occupancy is, by construction, the live outstanding count.
   cp_fetch_fifo #(
      .WIDTH (XLEN),
      .DEPTH (MAX_OUTST)
   ) u_tag_q (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .flush  (redirect_i),
      .push   (issue),
      .wdata  (pc_q),
      .pop    (rsp_take),
      .rdata  (tag_pc),
      .count  (outstanding)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_q <= RESET_PC;
      end else if (redirect_i) begin
         pc_q <= word_align(redirect_pc_i);
      end else if (issue) begin
         pc_q <= pc_q + 32'd4;
      end
   end

   // On redirect every live request becomes a discard, less one arriving right now.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         discard <= '0;
      end else if (redirect_i) begin
         discard <= discard + DISC_W'(outstanding) - DISC_W'(rsp_inflight);
      end else if (rsp_drop) begin
         discard <= discard - DISC_W'(1);
      end
   end

`ifdef CP_FETCH_PERF_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fetch_cnt_o <= '0;
         stall_cnt_o <= '0;
      end else begin
         if (handoff) begin
            fetch_cnt_o <= fetch_cnt_o + 32'd1;
         end
         if (instr_ready_i && !instr_valid_o) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
         end
      end
   end
`else
   // No performance counters in this build.
`endif

   a_outst_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
      int'(outstanding) <= MAX_OUTST);

   a_rvalid_expected : assert property (@(posedge clk_i) disable iff (!rst_ni)
      imem_rvalid_i |-> ((outstanding != '0) || (discard != '0)));

endmodule

`default_nettype wire

// File: tb/tb_cp_instr_fetch.sv
// tb_cp_instr_fetch: randomized scoreboard bench; a PC-sequence model predicts the decode stream.
`default_nettype none
`timescale 1ns/1ps

module tb_cp_instr_fetch;

   localparam int          DEPTH  = 4;
   localparam int          MAXO   = 2;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req;
   logic [31:0] addr;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        ivalid;
   logic        ready;
   logic [31:0] idata;
   logic [31:0] pc;
`ifdef CP_FETCH_PERF_EN
   logic [31:0] fetch_cnt;
   logic [31:0] stall_cnt;
`endif

   cp_instr_fetch #(
      .RESET_PC   (RST_PC),
      .FIFO_DEPTH (DEPTH),
      .MAX_OUTST  (MAXO)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .imem_req_o    (req),
      .imem_addr_o   (addr),
      .imem_gnt_i    (gnt),
      .imem_rvalid_i (rvalid),
      .imem_rdata_i  (rdata),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .instr_valid_o (ivalid),
      .instr_ready_i (ready),
      .instr_data_o  (idata),
      .pc_o          (pc)
`ifdef CP_FETCH_PERF_EN
      ,
      .fetch_cnt_o   (fetch_cnt),
      .stall_cnt_o   (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          handoffs = 0;
   int          issued = 0;
   int          stall_model = 0;
   logic [31:0] last_pc = 32'h0;

   int          p_gnt = 0;
   int          p_rv  = 0;
   int          p_rdy = 0;

   logic [31:0] mem_q[$];
   exp_t        exp_q[$];
   logic [31:0] exp_pc = RST_PC;
   logic [31:0] next_start = 32'h0;
   bit          flush_pending = 1'b0;
   exp_t        mon_e;

   // Memory content: odd-constant multiply keeps every address's word distinct.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic topup();
      while (exp_q.size() < 8) begin
         exp_q.push_back('{pc: exp_pc, instr: mem_word(exp_pc)});
         exp_pc = exp_pc + 32'd4;
      end
   endtask

   // One cycle of stimulus: memory grant/response, decode back-pressure, redirect.
   task automatic step(input logic redir, input logic [31:0] rpc);
      @(posedge clk);
      #1;
      if (flush_pending) begin
         exp_q.delete();
         exp_pc        = next_start;
         flush_pending = 1'b0;
      end
      topup();
      gnt   = ($urandom_range(99) < p_gnt);
      ready = ($urandom_range(99) < p_rdy);
      if (mem_q.size() > 0 && $urandom_range(99) < p_rv) begin
         rvalid = 1'b1;
         rdata  = mem_word(mem_q.pop_front());
      end else begin
         rvalid = 1'b0;
         rdata  = $urandom;
      end
      redirect    = redir;
      redirect_pc = redir ? rpc : $urandom;
      if (redir) begin
         flush_pending = 1'b1;
         next_start    = {rpc[31:2], 2'b00};
      end
   endtask

   task automatic wait_handoff(output bit seen);
      int h0;
      h0   = handoffs;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         step(1'b0, 32'h0);
         if (handoffs > h0) seen = 1'b1;
      end
   endtask

   task automatic do_redirect(input logic [31:0] rpc, input string tag);
      bit          seen;
      logic [31:0] aligned;
      aligned = {rpc[31:2], 2'b00};
      step(1'b1, rpc);
      p_rv = 100;
      step(1'b0, 32'h0);
      #1;
      chk({tag, "_req"}, 32'(req), 32'd1);
      chk({tag, "_addr"}, addr, aligned);
      wait_handoff(seen);
      chk({tag, "_first_pc"}, seen ? last_pc : 32'hDEAD_BEEF, aligned);
   endtask

   // Memory side: record every granted address in issue order.
   always @(negedge clk) begin
      if (rst_n && req && gnt) begin
         mem_q.push_back(addr);
         issued++;
      end
   end

   // Monitor: every decode handoff is popped against the model stream.
   always @(negedge clk) begin
      if (rst_n) begin
         if (ready && !ivalid) stall_model++;
         if (ivalid && ready) begin
            handoffs++;
            last_pc = pc;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL stream: got pc %h with no expected entry", pc);
            end else begin
               mon_e = exp_q.pop_front();
               if (pc !== mon_e.pc || idata !== mon_e.instr) begin
                  errors++;
                  $display("FAIL stream: got pc %h instr %h, expected pc %h instr %h",
                           pc, idata, mon_e.pc, mon_e.instr);
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      int h0;
      rst_n       = 1'b0;
      gnt         = 1'b0;
      rvalid      = 1'b0;
      rdata       = 32'h0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      ready       = 1'b1;
      topup();

      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
      end
      chk("rst_req", 32'(req), 32'd0);
      chk("rst_valid", 32'(ivalid), 32'd0);
      chk("rst_data", idata, 32'h0);
      chk("rst_pc", pc, 32'h0);

      rst_n = 1'b1;
      ready = 1'b0;
      #1;
      chk("rel_req", 32'(req), 32'd1);
      chk("rel_addr", addr, RST_PC);

      // Full-rate streaming.
      p_gnt = 100; p_rv = 100; p_rdy = 100;
      for (int i = 0; i < 6; i++) step(1'b0, 32'h0);
      h0 = handoffs;
      for (int i = 0; i < 20; i++) step(1'b0, 32'h0);
      chk("stream_rate", 32'(handoffs - h0), 32'd20);

      // Back-pressure: queue fills to exactly DEPTH, requests stop.
      p_rdy = 0;
      for (int i = 0; i < 12; i++) step(1'b0, 32'h0);
      #1;
      chk("bp_req", 32'(req), 32'd0);
      chk("bp_valid", 32'(ivalid), 32'd1);
      chk("bp_inflight", 32'(mem_q.size()), 32'd0);
      chk("bp_queued", 32'(issued - handoffs), 32'(DEPTH));
      p_rdy = 100;
      for (int i = 0; i < 8; i++) step(1'b0, 32'h0);

      // Redirects with MAXO responses held in flight.
      p_rv = 0;
      for (int i = 0; i < 4; i++) step(1'b0, 32'h0);
      chk("inflight_100", 32'(mem_q.size()), 32'(MAXO));
      do_redirect(32'h0000_0100, "redir_100");

      p_rv = 0;
      for (int i = 0; i < 4; i++) step(1'b0, 32'h0);
      do_redirect(32'h0000_0203, "redir_203");

      p_rv = 0;
      for (int i = 0; i < 2; i++) step(1'b0, 32'h0);
      do_redirect(32'hFFFF_FFFC, "wrap");
      wait_handoff(seen);
      chk("wrap_next_pc", seen ? last_pc : 32'hDEAD_BEEF, 32'h0);

      // Randomized traffic with back-pressure and occasional redirects.
      p_gnt = 60; p_rv = 50; p_rdy = 60;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(99) < 2) step(1'b1, $urandom);
         else                       step(1'b0, 32'h0);
      end

      // Drain, then quiesce so the counters are stable for comparison.
      p_gnt = 100; p_rv = 100; p_rdy = 100;
      for (int i = 0; i < 30; i++) step(1'b0, 32'h0);
      checks++;
      if (handoffs < 500) begin
         errors++;
         $display("FAIL total_handoffs: got %0d, expected at least 500", handoffs);
      end
      p_rdy = 0; p_gnt = 0;
      for (int i = 0; i < 4; i++) step(1'b0, 32'h0);
`ifdef CP_FETCH_PERF_EN
      chk("fetch_cnt", fetch_cnt, 32'(handoffs));
      chk("stall_cnt", stall_cnt, 32'(stall_model));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
